gun_aim_ctrl: RTL and testbench
===============================

# gun_aim_ctrl

Converts the four digital joystick direction bits into the 6-bit `gun_h` / `gun_v` aim coordinates consumed by the `williams2` core's gun inputs, stepping on the core's 4 ms tick with a three-speed acceleration profile and saturation at the screen edges. Sits between `hps_io` joystick decode and `williams2`, replacing ad-hoc position logic in the top level; runs entirely on the 12 MHz system clock.

## Interface
- `CENTER`, 32: position loaded on reset and on `recenter`.
- `POS_MAX`, 63: upper saturation bound; lower bound fixed at 0.
- `SLOW_DIV`, 4: ticks per step in SLOW.
- `MED_DIV`, 2: ticks per step in MEDIUM.
- `SLOW_TICKS`, 16: held ticks spent in SLOW, counting the first press tick.
- `MED_TICKS`, 32: held ticks spent in MEDIUM.
- `clock_12`  in  1  system clock, 12 MHz.
- `reset_n`  in  1  one clock; reset is synchronous and active-low.
- `tick_4ms`  in  1  level from core `cnt_4ms_o`; rising edge = one aim tick.
- `left`, `right`, `up`, `down`  in  1 each  active-high joystick bits.
- `recenter`  in  1  synchronous pulse; returns both axes to `CENTER`.
- `gun_h`  out  6  horizontal aim; 0 = left.
- `gun_v`  out  6  vertical aim; 0 = top.
- `aim_changed`  out  1  one-cycle pulse when either coordinate changed this cycle.

## Operation
- Tick detect: `tick_q` registers `tick_4ms`; `tick_ev = tick_4ms & ~tick_q`. Only `tick_ev` cycles advance the axis logic.
- Each axis is independent and identical. H: neg = `left`, pos = `right`. V: neg = `up`, pos = `down`.
- Direction per axis: NONE if neither bit or both bits are set; otherwise NEG or POS. The last direction is stored as `last_dir`.
- Axis FSM states: IDLE, SLOW, MEDIUM, FAST. `hold_cnt` is 8 bits, saturating at 255. `div_cnt` is 3 bits.
- On `tick_ev` with direction NONE: go to IDLE, `hold_cnt`=0, `div_cnt`=0, no step.
- On `tick_ev` from IDLE with a direction, or with a direction different from `last_dir`:
  - step once immediately;
  - go to SLOW with `hold_cnt`=1 and `div_cnt`=0.
- On `tick_ev` in SLOW or MEDIUM with the same direction:
  - `hold_cnt`++;
  - `div_cnt`++;
  - when the new `div_cnt` equals the state's divisor, step once and clear `div_cnt`.
- Promotions:
  - SLOW→MEDIUM on the tick where the new `hold_cnt` = `SLOW_TICKS`+1; that tick loads `div_cnt`=1 and does not step.
  - MEDIUM→FAST on the tick where the new `hold_cnt` = `SLOW_TICKS`+`MED_TICKS`+1; that tick does step.
  - FAST steps on every tick.
- A step is ±1, saturating at 0 and `POS_MAX`. A saturated step leaves the state and counters advancing normally and does not pulse `aim_changed`.
- `recenter` has priority over `tick_ev` in the same cycle: both axes go to `CENTER`, the FSMs go to IDLE, and the counters clear.
- `aim_changed` = 1 in the cycle after any change of `gun_h` or `gun_v`, including a change caused by `recenter` when the value differs from `CENTER`.

## Timing
- Reset values while `reset_n`=0 at a clock edge:
  - `gun_h` = `gun_v` = `CENTER`;
  - `aim_changed` = 0 and `tick_q` = 0;
  - FSMs in IDLE with all counters 0.
- Latency:
  - `gun_*` updates at the same clock edge that samples `tick_4ms`=1 with `tick_q`=0, so the new value is visible 1 clock after `tick_4ms` rises;
  - `aim_changed` follows one clock later.
- Joystick bits are sampled only on `tick_ev` cycles. Changes between ticks have no effect.
- `tick_4ms` held high for many cycles yields exactly one tick.
- Reset mid-hold discards all hold history. The first tick after release of reset behaves as an IDLE entry.

## Structure
- `gun_aim_pkg`:
  - `axis_state_t` enum {IDLE, SLOW, MEDIUM, FAST};
  - `dir_t` enum {NONE, NEG, POS};
  - default divisor and tick constants.
- Sub-module `gun_axis`: one FSM plus saturating position, instantiated twice. The top level holds only the tick detect, `recenter` fan-out and `aim_changed` logic.

## Test plan
- Reset: hold `reset_n`=0 for 2 clocks → `gun_h`=`gun_v`=32, `aim_changed`=0.
- Hold `right` with defaults:
  - `gun_h`=33 after tick 1, 34 after tick 5, 36 after tick 16;
  - 52 after tick 48, 53 after tick 49;
  - 63 after tick 59, still 63 after tick 70 with no `aim_changed` pulses after tick 59.
- `left`+`right` held together for 10 ticks → `gun_h` stays 32 and the FSM stays IDLE. Releasing `left` then gives 33 on the next tick.
- Reversal: hold `right` for 20 ticks (`gun_h`=38), then switch to `left` → 37 on the next tick, then the SLOW cadence (next step 4 ticks later).
- `recenter` and `tick_ev` in the same cycle while `down` is held at `gun_v`=40 → `gun_v`=32, `aim_changed` pulses once, and the next tick steps to 33.
- `tick_4ms` held high for 1000 clocks with `up` held → exactly one decrement (32→31).

Source files
------------

// File: rtl/gun_aim_pkg.sv
// Shared types, default tuning constants and the saturating step helper
// for the joystick-to-gun aim converter.
package gun_aim_pkg;

    typedef enum logic [1:0] {IDLE, SLOW, MEDIUM, FAST} axis_state_t;
    typedef enum logic [1:0] {NONE, NEG, POS} dir_t;

    localparam int POS_W          = 6;
    localparam int CENTER_DEF     = 32;
    localparam int POS_MAX_DEF    = 63;
    localparam int SLOW_DIV_DEF   = 4;
    localparam int MED_DIV_DEF    = 2;
    localparam int SLOW_TICKS_DEF = 16;
    localparam int MED_TICKS_DEF  = 32;

    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    // Opposing bits cancel, so a rocked stick reads as released.
    function automatic dir_t decode_dir(input logic neg_bit, input logic pos_bit);
        dir_t d;
        d = NONE;
        if (neg_bit && !pos_bit) begin
            d = NEG;
        end else if (pos_bit && !neg_bit) begin
            d = POS;
        end
        return d;
    endfunction

    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] cur,
                                                  input dir_t            dir,
                                                  input logic [POS_W-1:0] max_pos);
        logic [POS_W-1:0] r;
        r = cur;
        if (dir == NEG && cur != '0) begin
            r = cur - POS_ONE;
        end else if (dir == POS && cur != max_pos) begin
            r = cur + POS_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/gun_aim_if.sv
// Joystick, tick and aim-coordinate bundle between the joystick decode
// (master) and the aim controller (slave).
interface gun_aim_if;
    import gun_aim_pkg::*;

    logic             tick_4ms;
    logic             left;
    logic             right;
    logic             up;
    logic             down;
    logic             recenter;
    logic [POS_W-1:0] gun_h;
    logic [POS_W-1:0] gun_v;
    logic             aim_changed;

    modport master (
        output tick_4ms, left, right, up, down, recenter,
        input  gun_h, gun_v, aim_changed
    );

    modport slave (
        input  tick_4ms, left, right, up, down, recenter,
        output gun_h, gun_v, aim_changed
    );

endinterface

// File: rtl/gun_axis.sv
// One aim axis: hold-time acceleration FSM (SLOW/MEDIUM/FAST) driving a
// position that saturates at 0 and POS_MAX.
module gun_axis
    import gun_aim_pkg::*;
#(
    parameter int CENTER     = CENTER_DEF,
    parameter int POS_MAX    = POS_MAX_DEF,
    parameter int SLOW_DIV   = SLOW_DIV_DEF,
    parameter int MED_DIV    = MED_DIV_DEF,
    parameter int SLOW_TICKS = SLOW_TICKS_DEF,
    parameter int MED_TICKS  = MED_TICKS_DEF
) (
    input  logic             clock_12,
    input  logic             reset_n,
    input  logic             tick_ev,
    input  logic             recenter,
    input  logic             neg_bit,
    input  logic             pos_bit,
    output logic [POS_W-1:0] position
);

    localparam logic [POS_W-1:0] CENTER_W     = POS_W'(CENTER);
    localparam logic [POS_W-1:0] POS_MAX_W    = POS_W'(POS_MAX);
    localparam logic [2:0]       SLOW_DIV_W   = 3'(SLOW_DIV);
    localparam logic [2:0]       MED_DIV_W    = 3'(MED_DIV);
    localparam logic [7:0]       SLOW_PROMOTE = 8'(SLOW_TICKS + 1);
    localparam logic [7:0]       MED_PROMOTE  = 8'(SLOW_TICKS + MED_TICKS + 1);

    axis_state_t      state_reg, state_next;
    dir_t             last_dir_reg, last_dir_next;
    dir_t             dir;
    logic [7:0]       hold_cnt_reg, hold_cnt_next, hold_inc;
    logic [2:0]       div_cnt_reg, div_cnt_next, div_inc;
    logic [POS_W-1:0] position_reg, position_next;
    logic             step;

    always_ff @(posedge clock_12) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            last_dir_reg <= NONE;
            hold_cnt_reg <= '0;
            div_cnt_reg  <= '0;
            position_reg <= CENTER_W;
        end else begin
            state_reg    <= state_next;
            last_dir_reg <= last_dir_next;
            hold_cnt_reg <= hold_cnt_next;
            div_cnt_reg  <= div_cnt_next;
            position_reg <= position_next;
        end
    end

    always_comb begin
        dir           = decode_dir(neg_bit, pos_bit);
        hold_inc      = (hold_cnt_reg == 8'hFF) ? 8'hFF : hold_cnt_reg + 8'd1;
        div_inc       = div_cnt_reg + 3'd1;
        state_next    = state_reg;
        last_dir_next = last_dir_reg;
        hold_cnt_next = hold_cnt_reg;
        div_cnt_next  = div_cnt_reg;
        position_next = position_reg;
        step          = 1'b0;

        if (recenter) begin
            state_next    = IDLE;
            last_dir_next = NONE;
            hold_cnt_next = '0;
            div_cnt_next  = '0;
            position_next = CENTER_W;
        end else if (tick_ev) begin
            last_dir_next = dir;
            if (dir == NONE) begin
                state_next    = IDLE;
                hold_cnt_next = '0;
                div_cnt_next  = '0;
            end else if (state_reg == IDLE || dir != last_dir_reg) begin
                // Fresh press or reversal: immediate step, restart the profile.
                step          = 1'b1;
                state_next    = SLOW;
                hold_cnt_next = 8'd1;
                div_cnt_next  = '0;
            end else begin
                hold_cnt_next = hold_inc;
                case (state_reg)
                    SLOW: begin
                        if (hold_inc == SLOW_PROMOTE) begin
                            state_next   = MEDIUM;
                            div_cnt_next = 3'd1;
                        end else if (div_inc == SLOW_DIV_W) begin
                            step         = 1'b1;
                            div_cnt_next = '0;
                        end else begin
                            div_cnt_next = div_inc;
                        end
                    end
                    MEDIUM: begin
                        if (hold_inc == MED_PROMOTE) begin
                            state_next   = FAST;
                            step         = 1'b1;
                            div_cnt_next = '0;
                        end else if (div_inc == MED_DIV_W) begin
                            step         = 1'b1;
                            div_cnt_next = '0;
                        end else begin
                            div_cnt_next = div_inc;
                        end
                    end
                    FAST: begin
                        step = 1'b1;
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
            if (step) begin
                position_next = step_pos(position_reg, dir, POS_MAX_W);
            end
        end
    end

    assign position = position_reg;

endmodule

// File: rtl/gun_aim_ctrl.sv
// Joystick-to-gun aim converter: 4 ms tick edge detect, two independent
// accelerating axes, and a one-cycle pulse whenever either coordinate moves.
module gun_aim_ctrl
    import gun_aim_pkg::*;
#(
    parameter int CENTER     = CENTER_DEF,
    parameter int POS_MAX    = POS_MAX_DEF,
    parameter int SLOW_DIV   = SLOW_DIV_DEF,
    parameter int MED_DIV    = MED_DIV_DEF,
    parameter int SLOW_TICKS = SLOW_TICKS_DEF,
    parameter int MED_TICKS  = MED_TICKS_DEF
) (
    input  logic     clock_12,
    input  logic     reset_n,
    gun_aim_if.slave aim
);

    localparam logic [POS_W-1:0] CENTER_W = POS_W'(CENTER);

    logic             tick_q;
    logic             tick_ev;
    logic [1:0]       neg_bits;
    logic [1:0]       pos_bits;
    logic [POS_W-1:0] pos_out [2];
    logic [POS_W-1:0] gun_h_d;
    logic [POS_W-1:0] gun_v_d;
    logic             aim_changed_reg;

    assign tick_ev  = aim.tick_4ms & ~tick_q;
    // Index 0 is horizontal, index 1 is vertical.
    assign neg_bits = {aim.up,   aim.left};
    assign pos_bits = {aim.down, aim.right};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            gun_axis #(
                .CENTER     (CENTER),
                .POS_MAX    (POS_MAX),
                .SLOW_DIV   (SLOW_DIV),
                .MED_DIV    (MED_DIV),
                .SLOW_TICKS (SLOW_TICKS),
                .MED_TICKS  (MED_TICKS)
            ) u_axis (
                .clock_12 (clock_12),
                .reset_n  (reset_n),
                .tick_ev  (tick_ev),
                .recenter (aim.recenter),
                .neg_bit  (neg_bits[gi]),
                .pos_bit  (pos_bits[gi]),
                .position (pos_out[gi])
            );
        end
    endgenerate

    // Delayed copies let the change pulse trail the coordinate by one clock.
    always_ff @(posedge clock_12) begin
        if (!reset_n) begin
            tick_q          <= 1'b0;
            gun_h_d         <= CENTER_W;
            gun_v_d         <= CENTER_W;
            aim_changed_reg <= 1'b0;
        end else begin
            tick_q          <= aim.tick_4ms;
            gun_h_d         <= pos_out[0];
            gun_v_d         <= pos_out[1];
            aim_changed_reg <= (pos_out[0] != gun_h_d) || (pos_out[1] != gun_v_d);
        end
    end

    assign aim.gun_h       = pos_out[0];
    assign aim.gun_v       = pos_out[1];
    assign aim.aim_changed = aim_changed_reg;

endmodule

// File: tb/tb_gun_aim_ctrl.sv
// Directed bench for gun_aim_ctrl: acceleration profile, saturation,
// reversal, cancel, recenter priority, long tick and reset mid-hold.
module tb_gun_aim_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;
    int   pulse_cnt = 0;
    int   p0;

    gun_aim_if aim ();

    gun_aim_ctrl dut (
        .clock_12 (clk),
        .reset_n  (reset_n),
        .aim      (aim)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (aim.aim_changed === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        aim.tick_4ms = 1'b1;
        repeat (3) @(negedge clk);
        aim.tick_4ms = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic do_recenter();
        @(negedge clk);
        aim.recenter = 1'b1;
        @(negedge clk);
        aim.recenter = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        aim.tick_4ms = 1'b0;
        aim.left     = 1'b0;
        aim.right    = 1'b0;
        aim.up       = 1'b0;
        aim.down     = 1'b0;
        aim.recenter = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_gun_h", 16'(aim.gun_h), 16'd32);
        check("reset_gun_v", 16'(aim.gun_v), 16'd32);
        check("reset_aim_changed", 16'(aim.aim_changed), 16'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Hold right: first tick with latency checks, then profile.
        p0 = pulse_cnt;
        aim.right = 1'b1;
        @(negedge clk);
        aim.tick_4ms = 1'b1;
        @(negedge clk);
        check("t1_gun_h", 16'(aim.gun_h), 16'd33);
        check("t1_aim_changed_early", 16'(aim.aim_changed), 16'd0);
        @(negedge clk);
        check("t1_aim_changed_pulse", 16'(aim.aim_changed), 16'd1);
        @(negedge clk);
        aim.tick_4ms = 1'b0;
        repeat (2) @(negedge clk);
        run_ticks(4);
        check("t5_gun_h", 16'(aim.gun_h), 16'd34);
        run_ticks(11);
        check("t16_gun_h", 16'(aim.gun_h), 16'd36);
        run_ticks(32);
        check("t48_gun_h", 16'(aim.gun_h), 16'd52);
        run_ticks(1);
        check("t49_gun_h", 16'(aim.gun_h), 16'd53);
        run_ticks(10);
        check("t59_gun_h", 16'(aim.gun_h), 16'd63);
        check("t59_pulses", 16'(pulse_cnt - p0), 16'd31);
        run_ticks(11);
        check("t70_gun_h", 16'(aim.gun_h), 16'd63);
        check("t70_pulses", 16'(pulse_cnt - p0), 16'd31);
        check("t70_gun_v", 16'(aim.gun_v), 16'd32);
        aim.right = 1'b0;
        do_tick();
        p0 = pulse_cnt;
        do_recenter();
        check("recenter_gun_h", 16'(aim.gun_h), 16'd32);
        check("recenter_pulse", 16'(pulse_cnt - p0), 16'd1);

        // Both horizontal bits cancel.
        p0 = pulse_cnt;
        aim.left  = 1'b1;
        aim.right = 1'b1;
        run_ticks(10);
        check("both_gun_h", 16'(aim.gun_h), 16'd32);
        check("both_pulses", 16'(pulse_cnt - p0), 16'd0);
        aim.left = 1'b0;
        do_tick();
        check("both_release_gun_h", 16'(aim.gun_h), 16'd33);
        aim.right = 1'b0;
        do_tick();
        do_recenter();

        // Reversal restarts the SLOW cadence.
        aim.right = 1'b1;
        run_ticks(20);
        check("rev_pre_gun_h", 16'(aim.gun_h), 16'd38);
        aim.right = 1'b0;
        aim.left  = 1'b1;
        do_tick();
        check("rev_first_gun_h", 16'(aim.gun_h), 16'd37);
        run_ticks(3);
        check("rev_wait_gun_h", 16'(aim.gun_h), 16'd37);
        do_tick();
        check("rev_step_gun_h", 16'(aim.gun_h), 16'd36);
        aim.left = 1'b0;
        do_tick();
        do_recenter();

        // Recenter wins over a simultaneous tick.
        aim.down = 1'b1;
        run_ticks(24);
        check("down_gun_v", 16'(aim.gun_v), 16'd40);
        p0 = pulse_cnt;
        @(negedge clk);
        aim.tick_4ms = 1'b1;
        aim.recenter = 1'b1;
        @(negedge clk);
        aim.recenter = 1'b0;
        check("rc_tick_gun_v", 16'(aim.gun_v), 16'd32);
        repeat (3) @(negedge clk);
        aim.tick_4ms = 1'b0;
        repeat (2) @(negedge clk);
        check("rc_tick_pulses", 16'(pulse_cnt - p0), 16'd1);
        do_tick();
        check("rc_next_gun_v", 16'(aim.gun_v), 16'd33);
        aim.down = 1'b0;
        do_tick();
        do_recenter();

        // Long-high tick yields a single step.
        aim.up = 1'b1;
        @(negedge clk);
        aim.tick_4ms = 1'b1;
        repeat (1000) @(negedge clk);
        aim.tick_4ms = 1'b0;
        repeat (2) @(negedge clk);
        check("long_tick_gun_v", 16'(aim.gun_v), 16'd31);
        check("long_tick_gun_h", 16'(aim.gun_h), 16'd32);
        aim.up = 1'b0;
        do_tick();
        do_recenter();

        // Joystick activity between ticks is ignored.
        @(negedge clk);
        aim.right = 1'b1;
        repeat (3) @(negedge clk);
        aim.right = 1'b0;
        do_tick();
        check("between_ticks_gun_h", 16'(aim.gun_h), 16'd32);

        // Reset mid-hold discards history.
        aim.right = 1'b1;
        run_ticks(20);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_gun_h", 16'(aim.gun_h), 16'd32);
        check("midreset_aim_changed", 16'(aim.aim_changed), 16'd0);
        reset_n = 1'b1;
        do_tick();
        check("post_reset_gun_h", 16'(aim.gun_h), 16'd33);
        run_ticks(3);
        check("post_reset_slow_gun_h", 16'(aim.gun_h), 16'd33);

        // Saturation at the low edge: reverse from 33 and hold long.
        aim.right = 1'b0;
        aim.left  = 1'b1;
        run_ticks(70);
        check("sat_low_gun_h", 16'(aim.gun_h), 16'd0);
        aim.left = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
